// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control bundle layout, ALU operation
// encodings and a destination-register helper. The decode control unit
// imports the same package so both sides agree on bit positions.
package mips_pkg;

    // Width of the decoded control bundle
    localparam int CTRL_W = 12;

    // Register specifier width
    localparam int REG_W = 5;

    // Bit positions inside the control bundle
    localparam int CTRL_REGDST   = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_ALUOP_LO = 3;
    localparam int CTRL_ALUOP_HI = 5;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMTOREG = 8;
    localparam int CTRL_BRANCH   = 9;
    localparam int CTRL_JUMP     = 10;
    localparam int CTRL_LUICTR   = 11;

    // ALUOp encodings carried in ctrl[5:3]
    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SLL = 3'd3,
        ALU_SUB = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    // Destination register selection: R-type writes rd, I-type writes rt.
    // Instructions that do not write the register file report register 0
    // so downstream forwarding never matches them.
    function automatic logic [REG_W-1:0] destReg(
        input logic             regDst,
        input logic             regWrite,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd
    );
        logic [REG_W-1:0] sel;
        sel = regDst ? rd : rt;
        return regWrite ? sel : '0;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector. Flags when the instruction in EX is a load
// whose target register is read by the instruction currently in ID.
// Both source fields are compared regardless of whether ID actually reads
// rt; the occasional extra bubble is cheaper than decoding usage here.
module load_use_detect
    import mips_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard
);

    logic w_rtNonZero;
    logic w_rsMatch;
    logic w_rtMatch;

    // Register 0 is hardwired to zero, so a load into it never creates a dependency
    always_comb begin
        w_rtNonZero = (ex_rt != '0);
        w_rsMatch   = (ex_rt == id_rs);
        w_rtMatch   = (ex_rt == id_rt);
        hazard      = ex_mem_read & w_rtNonZero & (w_rsMatch | w_rtMatch);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard handling. Captures the decoded
// control bundle and operands for EX, replaces the EX instruction with a
// bubble on a load-use hazard or a flush, raises stall to freeze PC and IF/ID,
// and keeps a saturating count of hazard bubbles for performance debug.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       id_ctrl,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic [11:0]       ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [4:0]        ex_wreg,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic [CTRL_W-1:0] r_exCtrl;
    logic [DATA_W-1:0] r_exPc4;
    logic [DATA_W-1:0] r_exRsData;
    logic [DATA_W-1:0] r_exRtData;
    logic [DATA_W-1:0] r_exImm;
    logic [REG_W-1:0]  r_exRs;
    logic [REG_W-1:0]  r_exRt;
    logic [REG_W-1:0]  r_exRd;
    logic [REG_W-1:0]  r_exShamt;
    logic [REG_W-1:0]  r_exWreg;
    logic [CNT_W-1:0]  r_bubbleCnt;

    logic              w_hazard;
    logic              w_killCtrl;
    logic              w_countBubble;
    logic              w_cntSaturated;
    logic [REG_W-1:0]  w_wregNext;

    load_use_detect u_load_use_detect (
        .ex_mem_read (r_exCtrl[CTRL_MEMREAD]),
        .ex_rt       (r_exRt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hazard      (w_hazard)
    );

    // Derive bubble/stall decisions; a flush or hold overrides the hazard,
    // and a flushed slot is not a hazard bubble so it is not counted
    always_comb begin
        w_wregNext     = destReg(id_ctrl[CTRL_REGDST], id_ctrl[CTRL_REGWRITE], id_rt, id_rd);
        w_killCtrl     = flush_i | w_hazard;
        w_countBubble  = w_hazard & ~flush_i;
        w_cntSaturated = &r_bubbleCnt;
        stall_o        = w_hazard & ~flush_i & ~hold_i;
    end

    // Pipeline register: hold freezes everything, otherwise data always loads
    // while control and destination are zeroed to form a bubble when needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exCtrl    <= '0;
            r_exPc4     <= '0;
            r_exRsData  <= '0;
            r_exRtData  <= '0;
            r_exImm     <= '0;
            r_exRs      <= '0;
            r_exRt      <= '0;
            r_exRd      <= '0;
            r_exShamt   <= '0;
            r_exWreg    <= '0;
        end else if (!hold_i) begin
            r_exPc4     <= id_pc4;
            r_exRsData  <= id_rs_data;
            r_exRtData  <= id_rt_data;
            r_exImm     <= id_imm;
            r_exRs      <= id_rs;
            r_exRt      <= id_rt;
            r_exRd      <= id_rd;
            r_exShamt   <= id_shamt;
            if (w_killCtrl) begin
                r_exCtrl <= '0;
                r_exWreg <= '0;
            end else begin
                r_exCtrl <= id_ctrl;
                r_exWreg <= w_wregNext;
            end
        end
    end

    // Saturating bubble counter so a long run never wraps to a misleading small value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubbleCnt <= '0;
        end else if (!hold_i && w_countBubble && !w_cntSaturated) begin
            r_bubbleCnt <= r_bubbleCnt + 1'b1;
        end
    end

    // Drive the registered state onto the EX-facing ports
    always_comb begin
        ex_ctrl      = r_exCtrl;
        ex_pc4       = r_exPc4;
        ex_rs_data   = r_exRsData;
        ex_rt_data   = r_exRtData;
        ex_imm       = r_exImm;
        ex_rs        = r_exRs;
        ex_rt        = r_exRt;
        ex_rd        = r_exRd;
        ex_shamt     = r_exShamt;
        ex_wreg      = r_exWreg;
        bubble_cnt_o = r_bubbleCnt;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. A reference model predicts the EX register
// contents for every driven cycle and queues them; they are popped and compared
// one clock later. stall_o is compared combinationally right after driving.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int CW = 4;

    localparam logic [11:0] C_ADD = 12'h013;
    localparam logic [11:0] C_SW  = 12'h054;
    localparam logic [11:0] C_LW  = 12'h196;

    typedef struct packed {
        logic [11:0]  ctrl;
        logic [4:0]   wreg;
        logic [147:0] data;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [11:0]   id_ctrl;
    logic [DW-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
    logic          flush_i, hold_i;
    logic [11:0]   ex_ctrl;
    logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd, ex_shamt, ex_wreg;
    logic          stall_o;
    logic [CW-1:0] bubble_cnt_o;

    int   testsRun  = 0;
    int   failCount = 0;
    exp_t expQ[$];

    logic [11:0]   mCtrl;
    logic [4:0]    mRt;
    logic [4:0]    mWreg;
    logic [147:0]  mData;
    logic [CW-1:0] mCnt;

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_pc4(id_pc4),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .flush_i(flush_i), .hold_i(hold_i), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_wreg(ex_wreg), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        testsRun++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: predict the state after the coming rising edge and queue it
    task automatic modelUpdate();
        logic hz;
        logic [4:0] dst;
        hz = mCtrl[7] && (mRt != 5'd0) && ((mRt == id_rs) || (mRt == id_rt));
        if (!hold_i) begin
            mData = {id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_shamt};
            mRt   = id_rt;
            dst   = id_ctrl[0] ? id_rd : id_rt;
            if (flush_i || hz) begin
                mCtrl = 12'h000;
                mWreg = 5'd0;
            end else begin
                mCtrl = id_ctrl;
                mWreg = id_ctrl[1] ? dst : 5'd0;
            end
            if (!flush_i && hz && mCnt != 4'd15) mCnt = mCnt + 4'd1;
        end
        expQ.push_back('{ctrl: mCtrl, wreg: mWreg, data: mData, cnt: mCnt});
    endtask

    function automatic logic expectedStall();
        logic hz;
        hz = mCtrl[7] && (mRt != 5'd0) && ((mRt == id_rs) || (mRt == id_rt));
        return hz && !flush_i && !hold_i;
    endfunction

    task automatic modelReset();
        mCtrl = '0; mRt = '0; mWreg = '0; mData = '0; mCnt = '0;
        expQ.delete();
    endtask

    // Compare the EX registers against the prediction made one edge earlier
    task automatic checkOutput();
        exp_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            check("ex_ctrl", {148'd0, ex_ctrl}, {148'd0, e.ctrl});
            check("ex_wreg", {155'd0, ex_wreg}, {155'd0, e.wreg});
            check("ex_data", {12'd0, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
                              ex_rs, ex_rt, ex_rd, ex_shamt}, {12'd0, e.data});
            check("bubble_cnt", {156'd0, bubble_cnt_o}, {156'd0, e.cnt});
        end
    endtask

    task automatic applyStimulus(input logic [11:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic flush, input logic hold);
        id_ctrl    = ctrl;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_shamt   = 5'($urandom);
        id_pc4     = $urandom;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_imm     = $urandom;
        flush_i    = flush;
        hold_i     = hold;
    endtask

    // One pipeline cycle: check last edge's result, drive, check stall, predict
    task automatic cycle(input string tag, input logic [11:0] ctrl, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic flush, input logic hold);
        @(negedge clk);
        checkOutput();
        applyStimulus(ctrl, rs, rt, rd, flush, hold);
        #1;
        check(tag, {159'd0, stall_o}, {159'd0, expectedStall()});
        modelUpdate();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(12'h000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        modelReset();
        #2;
        check("reset_ctrl", {148'd0, ex_ctrl}, 160'd0);
        check("reset_cnt", {156'd0, bubble_cnt_o}, 160'd0);
        check("reset_stall", {159'd0, stall_o}, 160'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU pass-through and a store with no register write
        cycle("stall_add", C_ADD, 5'd3, 5'd7, 5'd5, 1'b0, 1'b0);
        cycle("stall_sw",  C_SW,  5'd4, 5'd6, 5'd9, 1'b0, 1'b0);

        // Load-use: one bubble, then the dependent add proceeds
        cycle("stall_lw",     C_LW,  5'd1, 5'd8, 5'd0,  1'b0, 1'b0);
        cycle("stall_hazard", C_ADD, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0);
        cycle("stall_retry",  C_ADD, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0);

        // Load into $0 never stalls
        cycle("stall_lw_r0",  C_LW,  5'd2, 5'd0, 5'd0,  1'b0, 1'b0);
        cycle("stall_r0_use", C_ADD, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0);

        // Flush coincident with a hazard wins
        cycle("stall_lw2",   C_LW,  5'd1, 5'd8, 5'd0,  1'b0, 1'b0);
        cycle("stall_flush", C_ADD, 5'd8, 5'd3, 5'd12, 1'b1, 1'b0);

        // Hold for three cycles over a hazard, then release
        cycle("stall_lw3", C_LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle("stall_hold", C_ADD, 5'd8, 5'd3, 5'd13, 1'b0, 1'b1);
        cycle("stall_release", C_ADD, 5'd8, 5'd3, 5'd13, 1'b0, 1'b0);
        cycle("stall_after",   C_ADD, 5'd8, 5'd3, 5'd13, 1'b0, 1'b0);

        // Asynchronous reset between edges with a nonzero counter
        @(negedge clk);
        checkOutput();
        check("pre_reset_cnt_nonzero", {159'd0, (bubble_cnt_o != 4'd0)}, 160'd1);
        applyStimulus(12'h0FF, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_ctrl", {148'd0, ex_ctrl}, 160'd0);
        check("async_wreg", {155'd0, ex_wreg}, 160'd0);
        check("async_data", {12'd0, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
                             ex_rs, ex_rt, ex_rd, ex_shamt}, 160'd0);
        check("async_cnt", {156'd0, bubble_cnt_o}, 160'd0);
        check("async_stall", {159'd0, stall_o}, 160'd0);
        modelReset();
        #1 rst = 1'b0;
        modelUpdate();

        // Drive the counter past its maximum to exercise saturation
        for (int i = 0; i < 17; i++) begin
            cycle("sat_lw",   C_LW,  5'd1, 5'd8, 5'd0,  1'b0, 1'b0);
            cycle("sat_haz",  C_ADD, 5'd8, 5'd2, 5'd14, 1'b0, 1'b0);
            cycle("sat_go",   C_ADD, 5'd8, 5'd2, 5'd14, 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput();
        check("sat_final", {156'd0, bubble_cnt_o}, 160'd15);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the MIPS pipeline, directly downstream of the decode control unit. Registers the decoded control bundle and operand data into the EX stage. Detects load-use hazards against the instruction currently in EX, inserts bubbles, and asserts a stall to freeze PC and IF/ID. Applies control-unit flushes and counts inserted bubbles for performance debug.

## Interface
Parameters:
- DATA_W, 32, datapath width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- id_ctrl  in  12  decoded control bundle, layout per package: [0] RegDst, [1] RegWrite, [2] ALUSrc, [5:3] ALUOp, [6] MemWrite, [7] MemRead, [8] MemToReg, [9] Branch, [10] Jump, [11] LUIctr
- id_pc4  in  DATA_W  PC+4 of ID instruction
- id_rs_data, id_rt_data  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction fields
- flush_i  in  1  kill ID instruction (IDFlush | EXFlush from control unit)
- hold_i  in  1  global pipeline freeze (memory wait)
- ex_ctrl  out  12  registered control bundle
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered data
- ex_rs, ex_rt, ex_rd, ex_shamt  out  5 each  registered fields
- ex_wreg  out  5  registered destination register
- stall_o  out  1  freeze PC and IF/ID this cycle
- bubble_cnt_o  out  CNT_W  count of inserted bubbles, saturating

## Operation
- Load-use hazard (combinational): hazard = ex_ctrl[MemRead] & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)). Both sources are compared unconditionally. Over-stalling on instructions that do not read rt is accepted.
- stall_o = hazard & ~flush_i & ~hold_i.
- Priority on each rising edge:
  - hold_i: all EX registers and counter keep their values.
  - flush_i: ex_ctrl <= 0, ex_wreg <= 0. Data registers load normally. Counter unchanged.
  - hazard: ex_ctrl <= 0, ex_wreg <= 0. Data registers load normally. Counter increments.
  - Otherwise: all registers load from ID.
- ex_wreg = (id_ctrl[RegDst] ? id_rd : id_rt), forced to 0 when id_ctrl[RegWrite] = 0. Registered with the same gating as ex_ctrl.
- A bubble has MemRead = 0, so a hazard lasts exactly one cycle per load. Back-to-back dependent instructions get a single bubble.
- Counter saturates at 2^CNT_W-1 and does not wrap.

## Timing
- Latency: ID inputs appear on ex_* one cycle after the capturing edge.
- stall_o is combinational from ex_ctrl/ex_rt (registered) and the id_rs/id_rt/flush_i/hold_i inputs. No state is involved.
- Reset (asynchronous, any time): all ex_* outputs, ex_wreg and bubble_cnt_o go to 0 immediately. stall_o falls because ex_ctrl[MemRead] = 0. The first edge after deassertion loads ID normally.
- Simultaneous flush_i and hazard: flush wins. stall_o = 0 and the counter does not increment.
- hold_i asserted during a hazard: stall_o = 0 and nothing changes. The hazard re-evaluates when hold_i drops.

## Structure
- Package mips_pkg: CTRL_W = 12, bit-index constants for every id_ctrl field, ALUOp encodings (0 and, 1 or, 2 add, 3 sll, 6 sub, 7 slt). The control unit uses the same package.
- Sub-module load_use_detect: purely combinational. Inputs are ex_mem_read, ex_rt, id_rs and id_rt; output is hazard.

## Test plan
- Reset mid-run with id_ctrl = 12'h0FF and a nonzero counter: assert rst asynchronously between edges. All outputs read 0 before the next edge.
- ALU pass-through: add with id_ctrl RegDst=1, RegWrite=1, ALUOp=2, id_rd=5, id_rt=7. Next cycle ex_ctrl equals the input and ex_wreg = 5. A sw with RegWrite=0 gives ex_wreg = 0.
- Load-use: lw with rt=8 in EX, then ID add with rs=8. stall_o = 1 for one cycle, the next ex_ctrl = 0, and bubble_cnt_o goes 0->1. The following cycle the add enters EX and stall_o = 0.
- ex_rt = 0 with MemRead=1 and id_rs = 0: no stall, no bubble.
- Flush + hazard in the same cycle: stall_o = 0, ex_ctrl = 0, counter unchanged.
- hold_i held 3 cycles during a hazard: ex_* frozen and stall_o = 0. After release, one bubble is inserted. Counter preloaded near max (CNT_W = 4, value 15) stays at 15 after a further bubble.
